// File: rtl/data_sender_arb_fsm.sv
// -----------------------------------------------------------------------------
// data_sender_arb_fsm
//
// Multi-channel data-sender control. Each of NUM_CH message channels runs its
// own IDLE/PEND/SEND/WAIT_TO/WAIT/FAIL state machine with an integrated ACK
// timeout counter and (optionally) a retry budget. Pending channels are
// granted round-robin onto one shared serial sender.
//
// Optional feature macro: DATA_SENDER_RETRY_LIMIT_EN
//   defined   : MAX_RETRIES retransmits per message, then the channel parks in
//               FAIL and raises its sticky link_fail bit.
//   undefined : unlimited retransmits, FAIL unreachable, link_fail tied low.
//
// Ports
//   clk               clock
//   rst_l             asynchronous active-low reset
//   game_active       low forces every channel to IDLE and clears its state
//   update_data_done  per-channel 1-cycle pulse: new data ready to send
//   ack_received      per-channel 1-cycle pulse: ACK for last message
//   send_done         shared sender finished the current message
//   send_start        1-cycle pulse: sender loads channel send_sel and starts
//   send_sel          channel being sent, held from send_start to send_done
//   busy              some channel is in SEND
//   link_fail         sticky per-channel failure flags
//
// Sender handshake: send_start is a single-cycle request carrying send_sel.
// The sender owns the transfer until it pulses send_done; no new send_start
// is issued while busy is high or in the cycle send_done is high, so at most
// one message is ever outstanding on the sender.
// -----------------------------------------------------------------------------
module data_sender_arb_fsm #(
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 3,
    localparam int SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              game_active,
    input  logic [NUM_CH-1:0] update_data_done,
    input  logic [NUM_CH-1:0] ack_received,
    input  logic              send_done,
    output logic              send_start,
    output logic [SEL_W-1:0]  send_sel,
    output logic              busy,
    output logic [NUM_CH-1:0] link_fail
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Elaboration-time guard against out-of-range configuration.
    if (NUM_CH < 1 || TIMEOUT_CYCLES < 2 || MAX_RETRIES < 0) begin : g_param_check
        $error("data_sender_arb_fsm: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PEND    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_TO = 3'd3,
        ST_WAIT    = 3'd4,
        ST_FAIL    = 3'd5
    } ch_state_t;

    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    // Set when a fresh update lands while the channel is being sent, so the
    // in-flight (now stale) message is followed by an immediate resend.
    logic [NUM_CH-1:0] resend_q;
    logic [NUM_CH-1:0] resend_d;

`ifdef DATA_SENDER_RETRY_LIMIT_EN
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

    logic [RTY_W-1:0]  rty_q   [NUM_CH];
    logic [RTY_W-1:0]  rty_d   [NUM_CH];
    logic [NUM_CH-1:0] fail_d;
    logic [NUM_CH-1:0] link_fail_q;
`endif

    // Round-robin search start: the channel after the last one granted.
    logic [SEL_W-1:0]  rr_start_q;
    logic              grant_vld;
    logic [SEL_W-1:0]  grant_idx;
    logic              busy_d;

    logic              send_start_q;
    logic [SEL_W-1:0]  send_sel_q;
    logic              busy_q;

    // Channel index 'k' positions after 'start', wrapping at NUM_CH.
    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] start,
                                                input int k);
        int s;
        s = int'(start) + k;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return SEL_W'(s);
    endfunction

    // -------------------------------------------------------------------------
    // Arbiter: grant only when the sender is idle and not finishing this cycle.
    // busy_q mirrors "some channel in SEND" for the current cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (game_active && !busy_q && !send_done) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!grant_vld && state_q[rr_idx(rr_start_q, k)] == ST_PEND) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_idx(rr_start_q, k);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d   = 1'b0;
        resend_d = resend_q;
`ifdef DATA_SENDER_RETRY_LIMIT_EN
        fail_d   = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef DATA_SENDER_RETRY_LIMIT_EN
            rty_d[i]   = rty_q[i];
`endif
            if (!game_active) begin
                state_d[i]  = ST_IDLE;
                cnt_d[i]    = '0;
                resend_d[i] = 1'b0;
`ifdef DATA_SENDER_RETRY_LIMIT_EN
                rty_d[i]    = '0;
`endif
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (update_data_done[i]) begin
                            state_d[i] = ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        if (grant_vld && grant_idx == SEL_W'(i)) begin
                            state_d[i]  = ST_SEND;
                            resend_d[i] = 1'b0;
                        end
                    end
                    ST_SEND: begin
                        if (send_done) begin
                            cnt_d[i]    = '0;
                            resend_d[i] = 1'b0;
                            // An update arriving in the final SEND cycle also
                            // makes the in-flight message stale.
                            if (resend_q[i] || update_data_done[i]) begin
                                state_d[i] = ST_PEND;
`ifdef DATA_SENDER_RETRY_LIMIT_EN
                                rty_d[i]   = '0;
`endif
                            end else begin
                                state_d[i] = ST_WAIT_TO;
                            end
                        end else if (update_data_done[i]) begin
                            resend_d[i] = 1'b1;
                        end
                    end
                    ST_WAIT_TO: begin
                        // Priority: new data, then timeout, then ACK. A
                        // coincident ACK and timeout therefore retransmits.
                        if (update_data_done[i]) begin
                            state_d[i] = ST_PEND;
                            cnt_d[i]   = '0;
`ifdef DATA_SENDER_RETRY_LIMIT_EN
                            rty_d[i]   = '0;
`endif
                        end else if (cnt_q[i] == CNT_LAST) begin
                            cnt_d[i] = '0;
`ifdef DATA_SENDER_RETRY_LIMIT_EN
                            if (rty_q[i] >= RTY_MAX) begin
                                state_d[i] = ST_FAIL;
                            end else begin
                                rty_d[i]   = rty_q[i] + 1'b1;
                                state_d[i] = ST_PEND;
                            end
`else
                            state_d[i] = ST_PEND;
`endif
                        end else if (ack_received[i]) begin
                            state_d[i] = ST_WAIT;
                            cnt_d[i]   = '0;
`ifdef DATA_SENDER_RETRY_LIMIT_EN
                            rty_d[i]   = '0;
`endif
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (update_data_done[i]) begin
                            state_d[i] = ST_PEND;
                        end
                    end
                    ST_FAIL: begin
                        // Parked until game_active drops.
                        state_d[i] = ST_FAIL;
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                    end
                endcase
            end

            if (state_d[i] == ST_SEND) begin
                busy_d = 1'b1;
            end
`ifdef DATA_SENDER_RETRY_LIMIT_EN
            fail_d[i] = (state_d[i] == ST_FAIL);
`endif
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
`ifdef DATA_SENDER_RETRY_LIMIT_EN
                rty_q[i]   <= '0;
`endif
            end
            resend_q     <= '0;
            rr_start_q   <= '0;
            send_start_q <= 1'b0;
            send_sel_q   <= '0;
            busy_q       <= 1'b0;
`ifdef DATA_SENDER_RETRY_LIMIT_EN
            link_fail_q  <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef DATA_SENDER_RETRY_LIMIT_EN
                rty_q[i]   <= rty_d[i];
`endif
            end
            resend_q     <= resend_d;
            send_start_q <= grant_vld;
            busy_q       <= busy_d;
            if (grant_vld) begin
                send_sel_q <= grant_idx;
                rr_start_q <= rr_idx(grant_idx, 1);
            end
`ifdef DATA_SENDER_RETRY_LIMIT_EN
            link_fail_q  <= fail_d;
`endif
        end
    end

    assign send_start = send_start_q;
    assign send_sel   = send_sel_q;
    assign busy       = busy_q;
`ifdef DATA_SENDER_RETRY_LIMIT_EN
    assign link_fail  = link_fail_q;
`else
    assign link_fail  = '0;
`endif

endmodule

// File: tb/tb_data_sender_arb_fsm.sv
// -----------------------------------------------------------------------------
// tb_data_sender_arb_fsm
//
// Directed bench for data_sender_arb_fsm with NUM_CH=2, TIMEOUT_CYCLES=8,
// MAX_RETRIES=2. Each expected send_start is queued as {cycle, channel} when
// the stimulus that causes it is driven; a negedge monitor pops and compares.
// Cycle n is the interval starting at the posedge where cyc becomes n.
// -----------------------------------------------------------------------------
module tb_data_sender_arb_fsm;

    localparam int NUM_CH = 2;
    localparam int TO     = 8;
    localparam int SEL_W  = 1;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic              game_active = 1'b0;
    logic [NUM_CH-1:0] update_data_done = '0;
    logic [NUM_CH-1:0] ack_received = '0;
    logic              send_done = 1'b0;
    logic              send_start;
    logic [SEL_W-1:0]  send_sel;
    logic              busy;
    logic [NUM_CH-1:0] link_fail;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] exp_q[$];

    data_sender_arb_fsm #(
        .NUM_CH         (NUM_CH),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (2)
    ) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .game_active      (game_active),
        .update_data_done (update_data_done),
        .ack_received     (ack_received),
        .send_done        (send_done),
        .send_start       (send_start),
        .send_sel         (send_sel),
        .busy             (busy),
        .link_fail        (link_fail)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int c, input int sel);
        logic [31:0] v;
        v = {c[27:0], sel[3:0]};
        return v;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [31:0] mon_head;
    logic        mon_exp;
    int          mon_cyc;

    always @(negedge clk) begin
        mon_exp = 1'b0;
        mon_head = '0;
        // Drop any entry whose cycle already passed: the start never came.
        while (exp_q.size() > 0 && int'(exp_q[0][31:4]) < cyc) begin
            mon_head = exp_q.pop_front();
            check("send_start_missed_cycle", cyc, int'(mon_head[31:4]));
        end
        if (exp_q.size() > 0 && int'(exp_q[0][31:4]) == cyc) begin
            mon_exp  = 1'b1;
            mon_head = exp_q[0];
        end
        if (send_start || mon_exp) begin
            check("send_start", int'(send_start), int'(mon_exp));
            if (mon_exp) begin
                void'(exp_q.pop_front());
                check("send_sel", int'(send_sel), int'(mon_head[3:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_upd(input logic [NUM_CH-1:0] b);
        update_data_done = b;
        tick();
        update_data_done = '0;
    endtask

    task automatic pulse_done_at(input int c);
        wait_until(c);
        send_done = 1'b1;
        tick();
        send_done = 1'b0;
    endtask

    task automatic pulse_ack_at(input int c, input logic [NUM_CH-1:0] b);
        wait_until(c);
        ack_received = b;
        tick();
        ack_received = '0;
    endtask

    task automatic do_reset();
        game_active = 1'b0;
        update_data_done = '0;
        ack_received = '0;
        send_done = 1'b0;
        @(negedge clk);
        rst_l = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_l = 1'b1;
        tick();
    endtask

    task automatic game_cycle();
        game_active = 1'b0;
        tick();
        game_active = 1'b1;
        tick();
    endtask

    // Both channels update together; 'first' is the expected first grant.
    task automatic contend(input int first, input string tag);
        int t;
        t = cyc;
        exp_q.push_back(pack(t + 2, first));
        exp_q.push_back(pack(t + 6, 1 - first));
        pulse_upd(2'b11);
        pulse_done_at(t + 4);
        check({tag, "_busy_gap"}, int'(busy), 0);
        pulse_done_at(t + 8);
        pulse_ack_at(t + 10, 2'b11);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t;

        // Reset values.
        #2;
        check("rst_send_start", int'(send_start), 0);
        check("rst_send_sel", int'(send_sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_link_fail", int'(link_fail), 0);
        do_reset();
        game_active = 1'b1;
        tick();

        // Single send + ACK.
        t = cyc;
        exp_q.push_back(pack(t + 2, 0));
        pulse_upd(2'b01);
        wait_until(t + 2);
        check("s1_busy_high", int'(busy), 1);
        pulse_done_at(t + 5);
        check("s1_busy_low", int'(busy), 0);
        pulse_ack_at(t + 8, 2'b01);
        wait_until(t + 30);
        check("s1_queue_empty", exp_q.size(), 0);

        // Pointer sits past ch0 after the single send: ch1 wins contention.
        game_cycle();
        contend(1, "rr_after_ch0");
        wait_until(cyc + 15);

        // Simultaneous updates after reset: ch0 first, then ch0 first again.
        do_reset();
        game_active = 1'b1;
        tick();
        contend(0, "sim_first");
        tick();
        contend(0, "sim_again");
        wait_until(cyc + 20);
        check("sim_queue_empty", exp_q.size(), 0);

        // Timeout / retry exhaustion (or unlimited retransmit).
        do_reset();
        game_active = 1'b1;
        tick();
        t = cyc;
        exp_q.push_back(pack(t + 2, 0));
        pulse_upd(2'b01);
        exp_q.push_back(pack(t + 4 + TO + 2, 0));
        pulse_done_at(t + 4);
        exp_q.push_back(pack(t + 15 + TO + 2, 0));
        pulse_done_at(t + 15);
        pulse_done_at(t + 26);
`ifdef DATA_SENDER_RETRY_LIMIT_EN
        wait_until(t + 34);
        check("rty_link_fail_before", int'(link_fail), 0);
        wait_until(t + 35);
        check("rty_link_fail_set", int'(link_fail), 1);
        check("rty_busy_fail", int'(busy), 0);
        wait_until(t + 60);
        check("rty_link_fail_sticky", int'(link_fail), 1);
        game_active = 1'b0;
        tick();
        check("rty_link_fail_clear", int'(link_fail), 0);
        game_active = 1'b1;
        tick();
`else
        exp_q.push_back(pack(t + 26 + TO + 2, 0));
        pulse_done_at(t + 37);
        exp_q.push_back(pack(t + 37 + TO + 2, 0));
        wait_until(t + 47);
        check("rty_link_fail_zero", int'(link_fail), 0);
        check("rty_busy_resend", int'(busy), 1);
        game_cycle();
`endif
        check("rty_queue_empty", exp_q.size(), 0);

        // ACK and timeout coincident: timeout wins.
        game_cycle();
        t = cyc;
        exp_q.push_back(pack(t + 2, 0));
        pulse_upd(2'b01);
        exp_q.push_back(pack(t + 3 + TO + 2, 0));
        pulse_done_at(t + 3);
        pulse_ack_at(t + 3 + TO, 2'b01);
        pulse_done_at(t + 14);
        pulse_ack_at(t + 16, 2'b01);
        wait_until(t + 35);
        check("coinc_queue_empty", exp_q.size(), 0);

        // Update during SEND: resend straight after send_done.
        game_cycle();
        t = cyc;
        exp_q.push_back(pack(t + 2, 0));
        pulse_upd(2'b01);
        wait_until(t + 3);
        pulse_upd(2'b01);
        exp_q.push_back(pack(t + 7, 0));
        pulse_done_at(t + 5);
        pulse_done_at(t + 8);
        pulse_ack_at(t + 10, 2'b01);
        wait_until(t + 30);
        check("resend_queue_empty", exp_q.size(), 0);

        // game_active falling mid-SEND.
        game_cycle();
        t = cyc;
        exp_q.push_back(pack(t + 2, 1));
        pulse_upd(2'b10);
        wait_until(t + 2);
        check("ga_busy_high", int'(busy), 1);
        game_active = 1'b0;
        tick();
        check("ga_busy_low", int'(busy), 0);
        game_active = 1'b1;
        wait_until(t + 25);

        // Asynchronous reset mid-SEND on ch1.
        t = cyc;
        exp_q.push_back(pack(t + 2, 1));
        pulse_upd(2'b10);
        wait_until(t + 2);
        @(negedge clk);
        #2;
        check("ar_busy_before", int'(busy), 1);
        rst_l = 1'b0;
        #1;
        check("ar_send_start", int'(send_start), 0);
        check("ar_send_sel", int'(send_sel), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_link_fail", int'(link_fail), 0);
        @(negedge clk);
        #1;
        rst_l = 1'b1;
        tick();
        wait_until(cyc + 25);
        check("ar_busy_after", int'(busy), 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
